// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the digest reader state encoding.
package sha256_pkg;

    localparam int unsigned SHA256_DIGEST_W = 256;
    localparam int unsigned SHA256_WORD_W   = 32;
    localparam int unsigned SHA256_NWORDS   = SHA256_DIGEST_W / SHA256_WORD_W;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_SEND = 1'b1
    } rd_state_e;

endpackage : sha256_pkg

// File: rtl/byte_swap_word.sv
// Combinational byte-order reversal of one WORD_W-bit word.
module byte_swap_word #(
    parameter int unsigned WORD_W = 32
) (
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] word_o
);

    localparam int unsigned NB = WORD_W / 8;

    for (genvar b = 0; b < NB; b++) begin : g_byte
        assign word_o[8*b +: 8] = word_i[WORD_W-8-8*b +: 8];
    end

endmodule : byte_swap_word

// File: rtl/digest_word_reader.sv
// Snapshots the stored digest on start and streams it out word by word over valid/ready.
module digest_word_reader
    import sha256_pkg::*;
#(
    parameter int unsigned DIGEST_W  = SHA256_DIGEST_W,
    parameter int unsigned WORD_W    = SHA256_WORD_W,
    parameter bit          MSW_FIRST = 1'b1,
    parameter bit          BYTE_SWAP = 1'b0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [DIGEST_W-1:0] digest_in,
    input  logic                start,
    input  logic                flush,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_word,
    output logic                out_valid,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    localparam int unsigned NW = DIGEST_W / WORD_W;
    localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;

    rd_state_e           state_q, state_d;
    logic [DIGEST_W-1:0] sreg_q, sreg_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                done_q, done_d;

    logic                last_c;
    logic [WORD_W-1:0]   raw_word_c;
    logic [WORD_W-1:0]   word_c;

    assign last_c = (cnt_q == CW'(NW - 1));

    // State, snapshot/shift register, word counter and done flop.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= RD_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Flush outranks a handshake; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (start && !flush) begin
                    sreg_d  = digest_in;
                    cnt_d   = '0;
                    state_d = RD_SEND;
                end
            end
            RD_SEND: begin
                if (flush) begin
                    state_d = RD_IDLE;
                end else if (out_ready) begin
                    if (last_c) begin
                        state_d = RD_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        sreg_d = MSW_FIRST ? (sreg_q << WORD_W) : (sreg_q >> WORD_W);
                    end
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // The current word always sits at the end of the shift register nearest the output.
    if (MSW_FIRST) begin : g_msw
        assign raw_word_c = sreg_q[DIGEST_W-1 -: WORD_W];
    end else begin : g_lsw
        assign raw_word_c = sreg_q[WORD_W-1:0];
    end

    if (BYTE_SWAP) begin : g_swap
        byte_swap_word #(
            .WORD_W (WORD_W)
        ) u_byte_swap (
            .word_i (raw_word_c),
            .word_o (word_c)
        );
    end else begin : g_noswap
        assign word_c = raw_word_c;
    end

    assign out_word  = word_c;
    assign out_valid = (state_q == RD_SEND);
    assign busy      = (state_q == RD_SEND);
    assign out_last  = (state_q == RD_SEND) && last_c;
    assign done      = done_q;

endmodule : digest_word_reader

// File: tb/tb_digest_word_reader.sv
// Scoreboard bench for digest_word_reader: MSW-first/plain and LSW-first/byte-swapped instances side by side.
module tb_digest_word_reader;

    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    logic         CLK = 1'b0;
    logic         RST;
    logic [255:0] digest_in;
    logic         start, flush, out_ready;

    logic [31:0]  out_word0, out_word1;
    logic         out_valid0, out_valid1, out_last0, out_last1;
    logic         busy0, busy1, done0, done1;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] e0, e1;

    always #5 CLK = ~CLK;

    digest_word_reader #(.MSW_FIRST(1'b1), .BYTE_SWAP(1'b0)) u_dut0 (
        .CLK(CLK), .RST(RST), .digest_in(digest_in), .start(start), .flush(flush),
        .out_ready(out_ready), .out_word(out_word0), .out_valid(out_valid0),
        .out_last(out_last0), .busy(busy0), .done(done0)
    );

    digest_word_reader #(.MSW_FIRST(1'b0), .BYTE_SWAP(1'b1)) u_dut1 (
        .CLK(CLK), .RST(RST), .digest_in(digest_in), .start(start), .flush(flush),
        .out_ready(out_ready), .out_word(out_word1), .out_valid(out_valid1),
        .out_last(out_last1), .busy(busy1), .done(done1)
    );

    function automatic logic [31:0] exp_word(input logic [255:0] d, input int k,
                                             input bit msw, input bit sw);
        logic [31:0] w;
        int idx;
        idx = msw ? (7 - k) : k;
        w = d[idx*32 +: 32];
        if (sw) w = {w[7:0], w[15:8], w[23:16], w[31:24]};
        return w;
    endfunction

    // Scoreboard: every handshake pops the oldest expected word of that instance.
    always @(negedge CLK) begin
        if (RST === 1'b1 && out_valid0 === 1'b1 && out_ready === 1'b1) begin
            n_vec++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL sb0_extra: got word %h, expected none", out_word0);
            end else begin
                e0 = q0.pop_front();
                if (out_word0 !== e0 || out_last0 !== (q0.size() == 0)) begin
                    n_err++;
                    $display("FAIL sb0_word: got %h last=%b, expected %h last=%b",
                             out_word0, out_last0, e0, (q0.size() == 0));
                end
            end
        end
        if (RST === 1'b1 && out_valid1 === 1'b1 && out_ready === 1'b1) begin
            n_vec++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL sb1_extra: got word %h, expected none", out_word1);
            end else begin
                e1 = q1.pop_front();
                if (out_word1 !== e1 || out_last1 !== (q1.size() == 0)) begin
                    n_err++;
                    $display("FAIL sb1_word: got %h last=%b, expected %h last=%b",
                             out_word1, out_last1, e1, (q1.size() == 0));
                end
            end
        end
        if (done0 === 1'b1) done_cnt0++;
        if (done1 === 1'b1) done_cnt1++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_expect(input logic [255:0] d);
        for (int k = 0; k < 8; k++) begin
            q0.push_back(exp_word(d, k, 1'b1, 1'b0));
            q1.push_back(exp_word(d, k, 1'b0, 1'b1));
        end
    endtask

    // Pulses start for one cycle; returns one cycle into SEND.
    task automatic start_readout();
        start = 1'b1;
        push_expect(digest_in);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge CLK);
            if (done0 === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; start = 1'b0; flush = 1'b0; out_ready = 1'b0; digest_in = IV;
        #3;
        n_vec++;
        if ({out_word0, out_valid0, out_last0, busy0, done0,
             out_word1, out_valid1, out_last1, busy1, done1} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h/%b%b%b%b %h/%b%b%b%b, expected all 0",
                     out_word0, out_valid0, out_last0, busy0, done0,
                     out_word1, out_valid1, out_last1, busy1, done1);
        end
        @(negedge CLK);
        RST = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge CLK);
        n_vec++;
        if ({out_valid0, busy0, done0} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_flush: got valid/busy/done %b%b%b, expected 000",
                     out_valid0, busy0, done0);
        end
        tick();
    endtask

    task automatic test_msw_order();
        int d0;
        logic [3:0] obs, expv;
        d0 = done_cnt0;
        out_ready = 1'b1;
        start_readout();
        for (int i = 1; i <= 9; i++) begin
            @(negedge CLK);
            obs  = {out_valid0, busy0, out_last0, done0};
            expv = (i <= 8) ? {2'b11, (i == 8), 1'b0} : 4'b0001;
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL msw_cycle%0d: got v/b/l/d %b, expected %b", i, obs, expv);
            end
            if (i == 1 || i == 8) begin
                n_vec++;
                if (out_word0 !== ((i == 1) ? 32'h6a09e667 : 32'h5be0cd19)) begin
                    n_err++;
                    $display("FAIL msw_word%0d: got %h", i, out_word0);
                end
            end
            tick();
        end
        n_vec++;
        if (done_cnt0 - d0 != 1 || q0.size() != 0) begin
            n_err++;
            $display("FAIL msw_done: got %0d done pulses, %0d words left, expected 1 and 0",
                     done_cnt0 - d0, q0.size());
        end
    endtask

    task automatic test_lsw_swap();
        int d1, n;
        logic [31:0] first_w, last_w;
        d1 = done_cnt1; n = 0; first_w = '0; last_w = '0;
        out_ready = 1'b1;
        start_readout();
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (out_valid1 === 1'b1) begin
                if (n == 0) first_w = out_word1;
                last_w = out_word1;
                n++;
            end
        end
        tick();
        n_vec++;
        if (first_w !== 32'h19cde05b || last_w !== 32'h67e6096a) begin
            n_err++;
            $display("FAIL lsw_ends: got first %h last %h, expected 19cde05b 67e6096a",
                     first_w, last_w);
        end
        n_vec++;
        if (n != 8 || done_cnt1 - d1 != 1) begin
            n_err++;
            $display("FAIL lsw_count: got %0d words %0d done, expected 8 and 1",
                     n, done_cnt1 - d1);
        end
    endtask

    task automatic test_backpressure();
        int d0, cyc;
        bit pat[4];
        bit prev_v, prev_r, seen;
        logic [31:0] prev_w;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        d0 = done_cnt0; prev_v = 1'b0; prev_r = 1'b1; prev_w = '0; seen = 1'b0;
        out_ready = pat[0];
        start_readout();
        cyc = 1;
        for (int i = 0; i < 60 && !seen; i++) begin
            out_ready = pat[cyc % 4];
            @(negedge CLK);
            if (done0 === 1'b1) seen = 1'b1;
            if (prev_v && !prev_r && out_valid0 === 1'b1) begin
                n_vec++;
                if (out_word0 !== prev_w) begin
                    n_err++;
                    $display("FAIL bp_stable: got %h, expected held %h", out_word0, prev_w);
                end
            end
            prev_v = out_valid0; prev_r = out_ready; prev_w = out_word0;
            tick();
            cyc++;
        end
        n_vec++;
        if (!seen || done_cnt0 - d0 != 1 || q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL bp_done: got done=%0d pulses=%0d left=%0d/%0d, expected 1 1 0/0",
                     seen, done_cnt0 - d0, q0.size(), q1.size());
        end
        out_ready = 1'b1;
    endtask

    task automatic test_snapshot();
        int d0;
        d0 = done_cnt0;
        out_ready = 1'b1;
        digest_in = IV;
        start = 1'b1;
        push_expect(IV);
        tick();
        start = 1'b0;
        digest_in = '0;
        wait_done("snap", 20);
        tick();
        n_vec++;
        if (done_cnt0 - d0 != 1 || q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL snap_done: got pulses=%0d left=%0d/%0d, expected 1 0/0",
                     done_cnt0 - d0, q0.size(), q1.size());
        end
        digest_in = IV;
    endtask

    task automatic test_flush();
        int d0;
        d0 = done_cnt0;
        out_ready = 1'b1;
        start_readout();
        tick(); tick(); tick();
        flush = 1'b1;
        @(negedge CLK);
        n_vec++;
        if (out_word0 !== 32'ha54ff53a || out_valid0 !== 1'b1) begin
            n_err++;
            $display("FAIL flush_pending: got %h v=%b, expected a54ff53a v=1", out_word0, out_valid0);
        end
        tick();
        flush = 1'b0;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            n_vec++;
            if ({out_valid0, busy0, done0, out_valid1} !== 4'b0000) begin
                n_err++;
                $display("FAIL flush_idle%0d: got v/b/d/v1 %b%b%b%b, expected 0000",
                         i, out_valid0, busy0, done0, out_valid1);
            end
            tick();
        end
        n_vec++;
        if (done_cnt0 != d0) begin
            n_err++;
            $display("FAIL flush_nodone: got %0d pulses, expected 0", done_cnt0 - d0);
        end
        start_readout();
        @(negedge CLK);
        n_vec++;
        if (out_word0 !== 32'h6a09e667 || out_valid0 !== 1'b1) begin
            n_err++;
            $display("FAIL flush_restart: got %h v=%b, expected 6a09e667 v=1", out_word0, out_valid0);
        end
        wait_done("flush_restart", 20);
        tick();
    endtask

    task automatic test_reset_and_start_ignore();
        int d0;
        out_ready = 1'b1;
        start_readout();
        tick(); tick();
        #2;
        RST = 1'b0;
        #1;
        n_vec++;
        if ({out_word0, out_valid0, out_last0, busy0, done0,
             out_word1, out_valid1, out_last1, busy1, done1} !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs: got %h/%b%b%b%b %h/%b%b%b%b, expected all 0",
                     out_word0, out_valid0, out_last0, busy0, done0,
                     out_word1, out_valid1, out_last1, busy1, done1);
        end
        q0.delete();
        q1.delete();
        @(negedge CLK);
        RST = 1'b1;
        tick();
        d0 = done_cnt0;
        start = 1'b1;
        push_expect(digest_in);
        for (int i = 0; i < 9; i++) tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            n_vec++;
            if (out_valid0 !== 1'b0) begin
                n_err++;
                $display("FAIL ign_restart%0d: got valid %b, expected 0", i, out_valid0);
            end
            tick();
        end
        n_vec++;
        if (done_cnt0 - d0 != 1 || q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL ign_done: got pulses=%0d left=%0d/%0d, expected 1 0/0",
                     done_cnt0 - d0, q0.size(), q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_msw_order();
        test_lsw_swap();
        test_backpressure();
        test_snapshot();
        test_flush();
        test_reset_and_start_ignore();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule : tb_digest_word_reader
